backprop_controll_sequencer: RTL and testbench
==============================================

// Module: backprop_controll_sequencer
// PURPOSE
// - Upstream driver of backprop_stack_controller: turns forward-pass row-completion events into the 66-bit
//   backprop_controll_bundle {is_store, start_train, current_input_layer[31:0], current_input_row[31:0]}.
// - Walks layer/row counters during the forward pass, then issues one start_train and waits for
//   the stack controller's active_train to rise and fall before reporting done.
// PARAMETERS
// - max_layer_size          4   maximum accepted num_layers
// - backprop_controll_size  66  bundle width; must equal 2+32+32
// PORTS
// - clk                 in   1   single clock, rising edge
// - rst_n               in   1   asynchronous active-low reset
// - start               in   1   pulse: latch num_layers/num_rows, begin pass
// - num_layers          in   32  layers in this pass, valid 1..max_layer_size
// - num_rows            in   32  rows per layer, valid >=1
// - train_en            in   1   sampled with start; 0 = forward only, no start_train
// - row_valid           in   1   forward datapath has finished the current row
// - row_ready           out  1   sequencer accepts row_valid this cycle (high only in STORE)
// - active_train        in   1   from backprop_stack_controller
// - backprop_controll_bundle out 66  registered control word to stack controller
// - busy                out  1   high in every state except IDLE
// - done                out  1   one-cycle pulse at end of pass
// - cfg_error           out  1   one-cycle pulse: start rejected for bad config
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; bundle, row_ready, busy, done, cfg_error all 0; counters 0.
// - States: IDLE -> STORE -> (TRAIN -> WAIT_HI -> WAIT_LO) -> IDLE.
// - IDLE: start=1 with 1<=num_layers<=max_layer_size and num_rows>=1 -> latch config, layer=0, row=0,
//   go STORE next cycle. Bad config -> cfg_error pulse next cycle, stay IDLE. Bundle held 0.
// - STORE: row_ready=1. On row_valid&row_ready: bundle <= {1,0,layer,row} for exactly one cycle
//   (1-cycle latency); else bundle <= 0. Then row++; row==num_rows-1 -> row=0, layer++.
// - Last accept (layer==num_layers-1, row==num_rows-1): train_en latched 1 -> TRAIN, else -> IDLE with done.
// - TRAIN: one cycle, bundle = {0,1,num_layers-1,0}; go WAIT_HI.
// - WAIT_HI: wait for active_train=1; WAIT_LO: wait for active_train=0, then done pulse, IDLE.
// - start while busy: ignored. row_valid outside STORE: ignored (row_ready=0).
// - start and row_valid same cycle in IDLE: row_valid ignored.
// - Counters are 32-bit, never wrap: pass ends exactly at last row of last layer.
// - Reset asserted mid-pass: immediate return to IDLE, all outputs 0, latched config discarded.
// CONFIGURATION
// - BACKPROP_SEQ_ABORT_EN defined: extra input abort (1 bit). abort=1 in any non-IDLE state -> next
//   cycle IDLE, bundle 0, busy 0, no done pulse. Has priority over row_valid/active_train.
// - Not defined: no abort port; a pass leaves IDLE only via completion or rst_n.
// TESTING
// - rst_n=0 mid-STORE (layer 1,row 2) -> all outputs 0 same cycle; after release, busy=0.
// - start, num_layers=2, num_rows=3, train_en=0, 6 row_valid -> bundles (0,0)(0,1)(0,2)(1,0)(1,1)(1,2)
//   with is_store=1, then done one cycle after the last; no start_train.
// - Same with train_en=1 -> after last store, one bundle {0,1,1,0}; active_train 0->1->0 -> done once.
// - start with num_layers=5 or num_rows=0 -> cfg_error pulse, busy stays 0.
// - row_valid held high continuously for num_layers=1,num_rows=4 -> 4 consecutive stores rows 0..3,
//   no extra store; start asserted during pass ignored.
// - (ABORT_EN) abort at layer 0,row 1 -> IDLE next cycle, no done; new start restarts at (0,0).

Source files
------------

// File: rtl/backprop_controll_sequencer.sv
// Turns forward-pass row completions into backprop_controll_bundle words, then runs one train handshake.
// Latency: store and start_train words are registered, 1 cycle after acceptance; done/cfg_error are 1-cycle registered pulses.
// Backpressure: row_ready is high only in STORE; optional abort port enabled by defining BACKPROP_SEQ_ABORT_EN.
module backprop_controll_sequencer #(
    parameter int max_layer_size         = 4,
    parameter int backprop_controll_size = 66
) (
    input  logic                              clk,
    input  logic                              rst_n,
`ifdef BACKPROP_SEQ_ABORT_EN
    input  logic                              abort,
`endif
    input  logic                              start,
    input  logic [31:0]                       num_layers,
    input  logic [31:0]                       num_rows,
    input  logic                              train_en,
    input  logic                              row_valid,
    output logic                              row_ready,
    input  logic                              active_train,
    output logic [backprop_controll_size-1:0] backprop_controll_bundle,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_TRAIN,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [backprop_controll_size-1:0] r_bundle;
    logic [backprop_controll_size-1:0] w_bundle_nxt;
    logic                              r_done;
    logic                              w_done_nxt;
    logic                              r_cfg_error;
    logic                              w_cfg_error_nxt;
    logic [31:0]                       r_layer;
    logic [31:0]                       w_layer_nxt;
    logic [31:0]                       r_row;
    logic [31:0]                       w_row_nxt;
    logic [31:0]                       r_num_layers;
    logic [31:0]                       r_num_rows;
    logic                              r_train_en;
    logic                              w_cfg_load;
    logic                              w_cfg_ok;
    logic                              w_accept;
    logic                              w_last_row;
    logic                              w_last_layer;

    assign w_cfg_ok     = (num_layers >= 32'd1) && (num_layers <= 32'(max_layer_size)) &&
                          (num_rows >= 32'd1);
    assign w_accept     = (r_state == S_STORE) && row_valid;
    assign w_last_row   = (r_row == r_num_rows - 32'd1);
    assign w_last_layer = (r_layer == r_num_layers - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bundle_nxt    = '0;
        w_done_nxt      = 1'b0;
        w_cfg_error_nxt = 1'b0;
        w_layer_nxt     = r_layer;
        w_row_nxt       = r_row;
        w_cfg_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        w_cfg_load  = 1'b1;
                        w_layer_nxt = '0;
                        w_row_nxt   = '0;
                        w_state_nxt = S_STORE;
                    end else begin
                        w_cfg_error_nxt = 1'b1;
                    end
                end
            end
            S_STORE: begin
                if (w_accept) begin
                    w_bundle_nxt = {1'b1, 1'b0, r_layer, r_row};
                    if (w_last_row && w_last_layer) begin
                        w_layer_nxt = '0;
                        w_row_nxt   = '0;
                        if (r_train_en) begin
                            w_state_nxt = S_TRAIN;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else if (w_last_row) begin
                        w_row_nxt   = '0;
                        w_layer_nxt = r_layer + 32'd1;
                    end else begin
                        w_row_nxt = r_row + 32'd1;
                    end
                end
            end
            S_TRAIN: begin
                w_bundle_nxt = {1'b0, 1'b1, r_num_layers - 32'd1, 32'd0};
                w_state_nxt  = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (active_train) begin
                    w_state_nxt = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!active_train) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
`ifdef BACKPROP_SEQ_ABORT_EN
        // Abort overrides whatever the current state decided above.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt  = S_IDLE;
            w_bundle_nxt = '0;
            w_done_nxt   = 1'b0;
            w_layer_nxt  = '0;
            w_row_nxt    = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bundle     <= '0;
            r_done       <= 1'b0;
            r_cfg_error  <= 1'b0;
            r_layer      <= '0;
            r_row        <= '0;
            r_num_layers <= '0;
            r_num_rows   <= '0;
            r_train_en   <= 1'b0;
        end else begin
            r_bundle    <= w_bundle_nxt;
            r_done      <= w_done_nxt;
            r_cfg_error <= w_cfg_error_nxt;
            r_layer     <= w_layer_nxt;
            r_row       <= w_row_nxt;
            if (w_cfg_load) begin
                r_num_layers <= num_layers;
                r_num_rows   <= num_rows;
                r_train_en   <= train_en;
            end
        end
    end

    assign row_ready                = (r_state == S_STORE);
    assign busy                     = (r_state != S_IDLE);
    assign backprop_controll_bundle = r_bundle;
    assign done                     = r_done;
    assign cfg_error                = r_cfg_error;

endmodule

// File: tb/tb_backprop_controll_sequencer.sv
// Scoreboard bench for backprop_controll_sequencer: expected bundle/done/cfg_error events are queued
// by the stimulus and popped by a negedge monitor whenever the DUT presents one.
module tb_backprop_controll_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] num_layers = '0;
    logic [31:0] num_rows = '0;
    logic        train_en = 1'b0;
    logic        row_valid = 1'b0;
    logic        row_ready;
    logic        active_train = 1'b0;
    logic [65:0] bundle;
    logic        busy;
    logic        done;
    logic        cfg_error;
`ifdef BACKPROP_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [67:0] exp_q[$];

    localparam logic [1:0] K_BUNDLE = 2'd0;
    localparam logic [1:0] K_DONE   = 2'd1;
    localparam logic [1:0] K_CFGERR = 2'd2;

    backprop_controll_sequencer #(
        .max_layer_size(4),
        .backprop_controll_size(66)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef BACKPROP_SEQ_ABORT_EN
        .abort(abort),
`endif
        .start(start),
        .num_layers(num_layers),
        .num_rows(num_rows),
        .train_en(train_en),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .active_train(active_train),
        .backprop_controll_bundle(bundle),
        .busy(busy),
        .done(done),
        .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, queue size %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    function automatic void push_store(input logic [31:0] l, input logic [31:0] r);
        exp_q.push_back({K_BUNDLE, 1'b1, 1'b0, l, r});
    endfunction

    function automatic void push_train(input logic [31:0] l);
        exp_q.push_back({K_BUNDLE, 1'b0, 1'b1, l, 32'd0});
    endfunction

    function automatic void push_done();
        exp_q.push_back({K_DONE, 66'd0});
    endfunction

    function automatic void push_cfgerr();
        exp_q.push_back({K_CFGERR, 66'd0});
    endfunction

    function automatic void observe(input string name, input logic [67:0] got);
        logic [67:0] want;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event got=%h required=none", name, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got=%h required=%h", name, got, want);
            end
        end
    endfunction

    // Monitor: bundle is compared before done so a coincident final store and done pop in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bundle !== 66'd0) observe("bundle", {K_BUNDLE, bundle});
            if (done)             observe("done", {K_DONE, 66'd0});
            if (cfg_error)        observe("cfg_error", {K_CFGERR, 66'd0});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=%0h required=%0h", name, got, want);
        end
    endtask

    task automatic drain(input string name);
        cyc(3);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc(1);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic begin_pass(input logic [31:0] nl, input logic [31:0] nr, input logic te);
        num_layers = nl;
        num_rows   = nr;
        train_en   = te;
        start      = 1'b1;
        cyc(1);
        start      = 1'b0;
    endtask

    task automatic send_rows(input int n);
        for (int i = 0; i < n; i++) begin
            row_valid = 1'b1;
            cyc(1);
            row_valid = 1'b0;
            cyc(1);
        end
    endtask

    initial begin
        #3;
        check("reset_outputs", {29'd0, row_ready, busy, done}, 32'd0);
        check("reset_bundle_lo", bundle[31:0], 32'd0);
        check("reset_bundle_hi", {bundle[65:34], 32'd0} == 64'd0 ? {30'd0, bundle[33:32]} : 32'hFFFF_FFFF, 32'd0);
        check("reset_cfg_error", {31'd0, cfg_error}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Rejected configurations
        push_cfgerr();
        begin_pass(32'd5, 32'd3, 1'b0);
        cyc(1);
        check("cfg_nl5_busy", {31'd0, busy}, 32'd0);
        push_cfgerr();
        begin_pass(32'd2, 32'd0, 1'b0);
        cyc(1);
        check("cfg_nr0_busy", {31'd0, busy}, 32'd0);
        push_cfgerr();
        begin_pass(32'd0, 32'd1, 1'b1);
        drain("cfg");
        check("cfg_busy_after", {31'd0, busy}, 32'd0);

        // Forward-only pass 2x3
        for (int l = 0; l < 2; l++)
            for (int r = 0; r < 3; r++) push_store(32'(l), 32'(r));
        push_done();
        begin_pass(32'd2, 32'd3, 1'b0);
        check("fwd_busy", {31'd0, busy}, 32'd1);
        check("fwd_row_ready", {31'd0, row_ready}, 32'd1);
        send_rows(6);
        drain("fwd");
        check("fwd_idle", {30'd0, busy, row_ready}, 32'd0);

        // Reset mid-STORE at layer 1, row 2
        for (int i = 0; i < 5; i++) push_store(32'(i / 3), 32'(i % 3));
        begin_pass(32'd2, 32'd3, 1'b0);
        send_rows(5);
        check("rst_pre_queue", exp_q.size(), 0);
        rst_n = 1'b0;
        #2;
        check("rst_mid_outputs", {28'd0, row_ready, busy, done, cfg_error}, 32'd0);
        check("rst_mid_bundle", {31'd0, |bundle}, 32'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        check("rst_after_busy", {31'd0, busy}, 32'd0);

        // Train pass 2x3 with active_train handshake
        for (int l = 0; l < 2; l++)
            for (int r = 0; r < 3; r++) push_store(32'(l), 32'(r));
        push_train(32'd1);
        push_done();
        begin_pass(32'd2, 32'd3, 1'b1);
        send_rows(6);
        cyc(4);
        check("train_wait_hi_busy", {31'd0, busy}, 32'd1);
        check("train_wait_hi_rdy", {31'd0, row_ready}, 32'd0);
        active_train = 1'b1;
        cyc(3);
        check("train_wait_lo_busy", {31'd0, busy}, 32'd1);
        active_train = 1'b0;
        drain("train");
        check("train_idle", {31'd0, busy}, 32'd0);

        // row_valid held high for 1x4; start coincident and mid-pass both ignored
        for (int r = 0; r < 4; r++) push_store(32'd0, 32'(r));
        push_done();
        row_valid  = 1'b1;
        begin_pass(32'd1, 32'd4, 1'b0);
        num_layers = 32'd3;
        start      = 1'b1;
        cyc(1);
        start      = 1'b0;
        cyc(5);
        row_valid  = 1'b0;
        drain("hold");
        check("hold_idle", {31'd0, busy}, 32'd0);

`ifdef BACKPROP_SEQ_ABORT_EN
        push_store(32'd0, 32'd0);
        begin_pass(32'd2, 32'd3, 1'b0);
        send_rows(1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        drain("abort");
        push_store(32'd0, 32'd0);
        push_done();
        begin_pass(32'd1, 32'd1, 1'b0);
        send_rows(1);
        drain("abort_restart");
`endif

        cyc(2);
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
